// File: rtl/uart_tx_frame.sv
// UART transmit framer: serialises valid/ready bytes as start, LSB-first data,
// optional parity and stop bit(s), with every bit edge aligned to a baud_clk rising edge.
module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ARM    = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] PARITY = 3'd4;
    localparam logic [2:0] STOP   = 3'd5;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    logic [2:0]           state;
    logic                 baud_d;
    logic                 tick;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_bit;
    logic [2:0]           bit_cnt;
    logic                 stop_cnt;
    logic                 tx_r;

    // baud_clk is already in the clk domain, so a single delay gives a clean edge pulse
    assign tick     = baud_clk & ~baud_d;
    assign tx_ready = (state == IDLE) && !reset;
    assign busy     = (state != IDLE);
    assign tx       = tx_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            baud_d     <= 1'b0;
            shift      <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= 3'd0;
            stop_cnt   <= 1'b0;
            tx_r       <= 1'b1;
        end else begin
            baud_d <= baud_clk;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shift      <= tx_data;
                        parity_bit <= (^tx_data) ^ (PARITY_ODD != 0);
                        state      <= ARM;
                    end
                end
                // ARM waits for a tick so the start bit lasts a full baud period
                ARM: begin
                    if (tick) begin
                        state <= START;
                        tx_r  <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        tx_r    <= shift[0];
                        bit_cnt <= 3'd0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx_r  <= parity_bit;
                            end else begin
                                state    <= STOP;
                                tx_r     <= 1'b1;
                                stop_cnt <= 1'b0;
                            end
                        end else begin
                            shift   <= shift >> 1;
                            tx_r    <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state    <= STOP;
                        tx_r     <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_cnt == LAST_STOP) begin
                            state <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four parameterisations share clk, reset and a
// baud_clk toggling every 34 clk; each frame is checked bit by bit against hand-written patterns.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset    = 1'b1;
    logic baud_clk = 1'b0;
    int   bcnt     = 0;
    int   cyc      = 0;
    int   rise_cyc = 0;

    // free-running baud source: 68 clk per bit, rise_cyc marks the edge baud_clk went high
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bcnt == 33) begin
            bcnt     <= 0;
            baud_clk <= ~baud_clk;
            if (!baud_clk) rise_cyc <= cyc + 1;
        end else begin
            bcnt <= bcnt + 1;
        end
    end

    logic [7:0] d0 = 8'h00, d1 = 8'h00, d2 = 8'h00;
    logic [6:0] d3 = 7'h00;
    logic [3:0] v  = 4'b0000;
    logic [3:0] txs, rdy, bsy;

    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(d0), .tx_valid(v[0]),
        .tx_ready(rdy[0]), .tx(txs[0]), .busy(bsy[0]));
    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(d1), .tx_valid(v[1]),
        .tx_ready(rdy[1]), .tx(txs[1]), .busy(bsy[1]));
    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(d2), .tx_valid(v[2]),
        .tx_ready(rdy[2]), .tx(txs[2]), .busy(bsy[2]));
    uart_tx_frame #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(d3), .tx_valid(v[3]),
        .tx_ready(rdy[3]), .tx(txs[3]), .busy(bsy[3]));

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_data(input int sel, input logic [7:0] data);
        case (sel)
            0:       d0 = data;
            1:       d1 = data;
            2:       d2 = data;
            default: d3 = data[6:0];
        endcase
    endtask

    // called at a negedge with the selected framer idle; one-cycle valid pulse
    task automatic send(input int sel, input logic [7:0] data);
        check($sformatf("ready_before_send%0d", sel), 32'(rdy[sel]), 32'd1);
        set_data(sel, data);
        v[sel] = 1'b1;
        @(negedge clk);
        v[sel] = 1'b0;
        set_data(sel, 8'hFF);
        check($sformatf("busy_after_accept%0d", sel), 32'(bsy[sel]), 32'd1);
        check($sformatf("ready_after_accept%0d", sel), 32'(rdy[sel]), 32'd0);
    endtask

    task automatic wait_start(input int sel, output bit ok);
        int w = 0;
        while (txs[sel] !== 1'b0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        ok = (txs[sel] === 1'b0);
        if (!ok) check($sformatf("start_wait%0d", sel), 32'(txs[sel]), 32'd0);
    endtask

    // pattern is the line level per bit period in transmit order, start bit first
    task automatic frame(input int sel, input string pattern, output int s_cyc, output int e_cyc);
        bit ok;
        logic expb;
        s_cyc = 0;
        e_cyc = 0;
        wait_start(sel, ok);
        if (!ok) return;
        s_cyc = cyc;
        check($sformatf("tick_align%0d", sel), 32'(cyc - rise_cyc), 32'd1);
        for (int i = 0; i < pattern.len(); i++) begin
            expb = (pattern[i] == "1");
            check($sformatf("s%0d_bit%0d_first", sel, i), 32'(txs[sel]), 32'(expb));
            repeat (67) @(negedge clk);
            check($sformatf("s%0d_bit%0d_last", sel, i), 32'(txs[sel]), 32'(expb));
            if (i == pattern.len() - 1)
                check($sformatf("s%0d_busy_in_stop", sel), 32'(bsy[sel]), 32'd1);
            @(negedge clk);
        end
        check($sformatf("s%0d_busy_end", sel), 32'(bsy[sel]), 32'd0);
        check($sformatf("s%0d_tx_idle", sel), 32'(txs[sel]), 32'd1);
        check($sformatf("s%0d_ready_end", sel), 32'(rdy[sel]), 32'd1);
        e_cyc = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, e1, s2, e2;
        bit ok;

        // reset held with a pending byte: nothing may be accepted
        reset = 1'b1;
        v[0]  = 1'b1;
        d0    = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            check("rst_tx", 32'(txs[0]), 32'd1);
            check("rst_ready", 32'(rdy[0]), 32'd0);
            check("rst_busy", 32'(bsy[0]), 32'd0);
        end
        reset = 1'b0;
        v[0]  = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(rdy[0]), 32'd1);
        check("post_rst_busy", 32'(bsy[0]), 32'd0);
        check("post_rst_tx", 32'(txs[0]), 32'd1);
        repeat (5) @(negedge clk);

        // 8N1 0x55
        send(0, 8'h55);
        frame(0, "0101010101", s1, e1);

        // even and odd parity on 0x07
        send(1, 8'h07);
        frame(1, "01110000011", s1, e1);
        send(2, 8'h07);
        frame(2, "01110000001", s1, e1);

        // 7 data bits, 2 stop bits, 0x41
        send(3, 8'h41);
        frame(3, "0100000111", s1, e1);

        // back-to-back with valid held: 0x3C must wait for IDLE
        repeat (10) @(negedge clk);
        check("b2b_ready", 32'(rdy[0]), 32'd1);
        d0   = 8'hA5;
        v[0] = 1'b1;
        @(negedge clk);
        d0 = 8'h3C;
        check("b2b_busy1", 32'(bsy[0]), 32'd1);
        frame(0, "0101001011", s1, e1);
        @(negedge clk);
        check("b2b_accept_next_cycle", 32'(bsy[0]), 32'd1);
        v[0] = 1'b0;
        d0   = 8'hFF;
        frame(0, "0001111001", s2, e2);
        check("b2b_high_gap", 32'(s2 - (s1 + 9 * 68)), 32'd136);

        // reset during data bit 4 of 0xF0, then a clean 0x81
        repeat (10) @(negedge clk);
        send(0, 8'hF0);
        wait_start(0, ok);
        repeat (5 * 68 + 34) @(negedge clk);
        check("mid_busy", 32'(bsy[0]), 32'd1);
        check("mid_bit4", 32'(txs[0]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_tx", 32'(txs[0]), 32'd1);
        check("abort_busy", 32'(bsy[0]), 32'd0);
        check("abort_ready", 32'(rdy[0]), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_after", 32'(rdy[0]), 32'd1);
        repeat (150) @(negedge clk);
        check("no_resume_tx", 32'(txs[0]), 32'd1);
        check("no_resume_busy", 32'(bsy[0]), 32'd0);
        send(0, 8'h81);
        frame(0, "0100000011", s1, e1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmit framer; sits directly downstream of the baud-rate generator.
- Consumes the generator's square-wave baud clock, in the same clk domain.
- Serialises parallel bytes from a valid/ready source onto tx as start, data LSB-first, optional parity, then stop bit(s).
- One bit period equals one full period of baud_clk, measured rising edge to rising edge.

Parameters:
- DATA_BITS, 8, data bits per frame (legal 5..8).
- PARITY_EN, 0, 1 = append a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).
- STOP_BITS, 1, number of stop bits (legal 1 or 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- baud_clk  input  1  baud square wave from the generator, registered in the clk domain.
- tx_data  input  DATA_BITS  byte to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  framer can accept a byte this cycle.
- tx  output  1  serial line, idle high, registered.
- busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Reset values: tx=1, busy=0, state=IDLE, baud_d=0, shift register=0, counters=0.
- tx_ready = (state==IDLE) && !reset; it is 0 during reset.
- Reset asserted mid-frame: abort on the next clk edge. tx returns to 1 immediately; the partial frame is discarded and not resumed.
- Tick generation: baud_d registers baud_clk. tick = baud_clk & ~baud_d, a one-clk pulse per baud_clk rising edge. No synchronizer is needed (same domain).
- Handshake: a transfer occurs on a clk edge where tx_valid && tx_ready.
  - At that edge, latch tx_data into the shift register and latch the parity bit (XOR of the data bits, inverted if PARITY_ODD).
  - Then go to ARM. tx_data may change after the accepting edge.
- FSM states: IDLE, ARM, START, DATA, PARITY, STOP. All transitions other than IDLE->ARM occur only on tick.
  - ARM: tx=1. On tick -> START, tx<=0.
  - START: on tick -> DATA, tx<=shift[0], bit_cnt<=0.
  - DATA: on tick:
    - if bit_cnt==DATA_BITS-1: -> PARITY with tx<=parity if PARITY_EN, else -> STOP with tx<=1 and stop_cnt<=0;
    - otherwise shift right, tx<=next bit, bit_cnt++.
  - PARITY: on tick -> STOP, tx<=1, stop_cnt<=0.
  - STOP: on tick, if stop_cnt==STOP_BITS-1 -> IDLE; otherwise stop_cnt++. tx stays 1.
- tx changes only on the clk edge where tick=1. It therefore changes 1 clk after the baud_clk rising edge is visible in the clk domain, and every bit lasts exactly one baud period.
- Back-to-back: the next byte can be accepted the cycle after the STOP->IDLE transition. Its start bit begins at the following tick, so consecutive frames are separated by exactly one extra idle-high bit period.
- tx_valid asserted while busy: no transfer; the source must hold tx_data until tx_ready.
- Baud-rate change mid-frame (generator sel change): no special handling. Bit timing simply follows the baud_clk edges.
- Ticks during IDLE are ignored.
- Widths: bit_cnt is 3 bits, stop_cnt is 1 bit, shift register is DATA_BITS.

Test Plan:
- Reset: hold reset 3 cycles with tx_valid=1 -> tx=1, tx_ready=0, busy=0 throughout. After release, tx_ready=1 next cycle and no byte was accepted during reset.
- 8N1, baud_clk toggling every 34 clk, send 0x55 -> tx over 10 bit periods of 68 clk each = 0,1,0,1,0,1,0,1,0,1. Each transition lands 1 clk after a baud_clk rising edge. busy drops after the stop bit.
- Parity: PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1. Same byte with PARITY_ODD=1 -> parity bit 0. Frame is 11 bits.
- STOP_BITS=2, DATA_BITS=7, send 0x41 -> 0, 1,0,0,0,0,0,1, 1,1, then IDLE.
- Back-to-back: tx_valid held high with 0xA5 then 0x3C -> second accept occurs 1 cycle after busy falls. Line is high for exactly 2 bit periods between frames. 0x3C is not sampled while busy.
- Reset asserted during data bit 4 of 0xF0 -> tx=1 on the next clk and state is IDLE. A subsequent 0x81 transmits a complete, correct frame.
